// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: moves one cache line between a line-wide requester and a word-wide bank.
// Optional feature: define MEM_LINE_CTRL_RANGE_CHECK_EN to reject lines that fall past MEM_DEPTH.
module mem_line_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ACCESS_LAT     = 2,
    parameter int MEM_DEPTH      = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [27:0]                   req_addr,
    input  logic [32*WORDS_PER_LINE-1:0]  req_wline,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [32*WORDS_PER_LINE-1:0]  resp_rline,
    output logic                          resp_err,
    output logic [27:0]                   mem_addr,
    output logic                          mem_write_en,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata
);
    localparam int LW     = 32 * WORDS_PER_LINE;
    localparam int BEAT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int WAIT_W = (ACCESS_LAT > 0) ? $clog2(ACCESS_LAT + 1) : 1;
    localparam logic [27:0]       ALIGN_MASK = ~28'(WORDS_PER_LINE - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(ACCESS_LAT);

    if (MEM_DEPTH < WORDS_PER_LINE) begin : g_depth_check
        $error("mem_line_ctrl: MEM_DEPTH must hold at least one line");
    end

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
    // a response on a rising edge with resp_valid && resp_ready; valid never waits on ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [27:0]       base;
    logic              we_q;
    logic [LW-1:0]     wline_q;
    logic [LW-1:0]     rline_q;
    logic [BEAT_W-1:0] beat;
    logic [WAIT_W-1:0] wait_cnt;

    logic [27:0]       aligned_addr;
    logic              beat_done;
    logic              range_err;
    logic [31:0]       wword;

    assign aligned_addr = req_addr & ALIGN_MASK;
    assign beat_done    = (state == BUSY) && (wait_cnt == LAST_WAIT);
    assign wword        = wline_q[32*beat +: 32];

`ifdef MEM_LINE_CTRL_RANGE_CHECK_EN
    logic err_q;
    assign range_err = ({4'd0, aligned_addr} + 32'(WORDS_PER_LINE)) > 32'(MEM_DEPTH);
    assign resp_err  = err_q;
`else
    assign range_err = 1'b0;
    assign resp_err  = 1'b0;
`endif

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign resp_rline   = rline_q;
    assign mem_addr     = (state == BUSY) ? base + 28'(beat) : 28'd0;
    assign mem_write_en = beat_done && we_q;
    assign mem_wdata    = ((state == BUSY) && we_q) ? wword : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            we_q     <= 1'b0;
            wline_q  <= '0;
            rline_q  <= '0;
            beat     <= '0;
            wait_cnt <= '0;
`ifdef MEM_LINE_CTRL_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base     <= aligned_addr;
                        we_q     <= req_we;
                        wline_q  <= req_wline;
                        beat     <= '0;
                        wait_cnt <= '0;
`ifdef MEM_LINE_CTRL_RANGE_CHECK_EN
                        err_q    <= range_err;
`endif
                        // A rejected line skips the bank entirely and answers with zeros.
                        if (range_err) begin
                            rline_q <= '0;
                            state   <= RESP;
                        end else begin
                            rline_q <= req_we ? req_wline : '0;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (wait_cnt == LAST_WAIT) begin
                        wait_cnt <= '0;
                        if (!we_q) begin
                            rline_q[32*beat +: 32] <= mem_rdata;
                        end
                        if (beat == LAST_BEAT) begin
                            state <= RESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Bench for mem_line_ctrl: two instances (ACCESS_LAT=2 and 0), each with a word bank,
// a table of directed lines, a mid-write reset sequence and random lines against a line-level model.
module tb_mem_line_ctrl;
  localparam int N     = 4;
  localparam int LW    = 32 * N;
  localparam int DEPTH = 256;
  localparam int W     = 77;  // {dut id, cycle[15:0], addr[27:0], data[31:0]}

  // clock / reset
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst          [2];
  logic          req_valid    [2];
  logic          req_ready    [2];
  logic          req_we       [2];
  logic [27:0]   req_addr     [2];
  logic [LW-1:0] req_wline    [2];
  logic          resp_valid   [2];
  logic          resp_ready   [2];
  logic [LW-1:0] resp_rline   [2];
  logic          resp_err     [2];
  logic [27:0]   mem_addr     [2];
  logic          mem_write_en [2];
  logic [31:0]   mem_wdata    [2];
  logic [31:0]   mem_rdata    [2];

  mem_line_ctrl #(.WORDS_PER_LINE(N), .ACCESS_LAT(2), .MEM_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wline(req_wline[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rline(resp_rline[0]),
    .resp_err(resp_err[0]), .mem_addr(mem_addr[0]), .mem_write_en(mem_write_en[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_line_ctrl #(.WORDS_PER_LINE(N), .ACCESS_LAT(0), .MEM_DEPTH(DEPTH)) u_dut_lat0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wline(req_wline[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rline(resp_rline[1]),
    .resp_err(resp_err[1]), .mem_addr(mem_addr[1]), .mem_write_en(mem_write_en[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] init_word(input int d, input int i);
    if (i < 4) return 32'hA0 + 32'(16 * i);
    return 32'h5000_0000 + 32'(d << 16) + 32'(i);
  endfunction

  // bank environment and strobe monitor
  logic [31:0]  bank [2][DEPTH];
  logic [W-1:0] obs_q[$];
  logic         init_bank;
  int           cyc;

  assign mem_rdata[0] = bank[0][mem_addr[0][7:0]];
  assign mem_rdata[1] = bank[1][mem_addr[1][7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (init_bank) begin
        for (int i = 0; i < DEPTH; i++) bank[d][i] <= init_word(d, i);
      end else if (mem_write_en[d]) begin
        bank[d][mem_addr[d][7:0]] <= mem_wdata[d];
        obs_q.push_back({1'(d), 16'(cyc), mem_addr[d], mem_wdata[d]});
      end
    end
  end

  // scoreboard and line-level model
  logic [W-1:0] exp_q[$];
  logic [31:0]  ref_mem [2][DEPTH];
  int           n_checks;
  int           n_errors;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [27:0] base);
`ifdef MEM_LINE_CTRL_RANGE_CHECK_EN
    return (int'(base) + N) > DEPTH;
`else
    return base > 28'hFFF_FFFF;
`endif
  endfunction

  task automatic compare_strobes(input string tag);
    check({tag, " strobe count"}, LW'(obs_q.size()), LW'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check({tag, " strobe"}, LW'(obs_q.pop_front()), LW'(exp_q.pop_front()));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // driver: one line request, response handshake, full comparison against the model
  task automatic run_line(input int d, input bit we, input logic [27:0] addr,
                          input logic [LW-1:0] wline, input int hold, input bit early_ready,
                          input string tag, output logic [LW-1:0] got_rline, output logic got_err);
    logic [27:0]   base;
    logic [LW-1:0] exp_line;
    bit            err, addr_bad, wdata_bad, ready_bad, stable_bad;
    int            lat, exp_lat, acc, l, h_n;
    l        = lat_of(d);
    h_n      = early_ready ? 0 : hold;
    base     = addr & ~28'(N - 1);
    err      = model_err(base);
    exp_line = '0;
    if (!err) begin
      for (int k = 0; k < N; k++) begin
        if (we) exp_line[32*k +: 32] = wline[32*k +: 32];
        else    exp_line[32*k +: 32] = ref_mem[d][(int'(base) + k) % DEPTH];
      end
    end
    exp_lat = err ? 1 : N * (l + 1) + 1;

    check({tag, " req_ready idle"}, LW'(req_ready[d]), 1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wline[d] = wline;
    @(posedge clk);
    acc = cyc;
    if (we && !err) begin
      for (int k = 0; k < N; k++) begin
        exp_q.push_back({1'(d), 16'(acc + (k + 1) * (l + 1)), base + 28'(k), wline[32*k +: 32]});
        ref_mem[d][(int'(base) + k) % DEPTH] = wline[32*k +: 32];
      end
    end
    #1;
    req_valid[d] = 1'b0;
    req_we[d]    = 1'b0;
    req_addr[d]  = '0;
    req_wline[d] = '0;
    if (early_ready) resp_ready[d] = 1'b1;

    lat = 1; addr_bad = 0; wdata_bad = 0; ready_bad = 0;
    while (!resp_valid[d] && lat < 200) begin
      if (mem_addr[d] !== base + 28'((lat - 1) / (l + 1))) addr_bad = 1;
      if (!we && mem_wdata[d] !== 32'd0) wdata_bad = 1;
      if (req_ready[d] !== 1'b0) ready_bad = 1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, LW'(lat), LW'(exp_lat));
    if (!err) begin
      check({tag, " busy mem_addr"}, LW'(addr_bad), 0);
      check({tag, " busy req_ready"}, LW'(ready_bad), 0);
      if (!we) check({tag, " read mem_wdata"}, LW'(wdata_bad), 0);
    end

    got_rline = resp_rline[d];
    got_err   = resp_err[d];
    stable_bad = 0;
    if (h_n > 0) begin
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = 28'h20;
      req_wline[d] = {4{32'hDEAD_BEEF}};
    end
    for (int h = 0; h < h_n; h++) begin
      @(posedge clk);
      #1;
      if (resp_valid[d] !== 1'b1 || resp_rline[d] !== got_rline ||
          resp_err[d] !== got_err || req_ready[d] !== 1'b0) stable_bad = 1;
    end
    if (h_n > 0) check({tag, " hold stable"}, LW'(stable_bad), 0);
    check({tag, " resp_rline"}, resp_rline[d], exp_line);
    check({tag, " resp_err"}, LW'(resp_err[d]), LW'(err));

    resp_ready[d] = 1'b1;
    req_valid[d]  = 1'b0;
    req_we[d]     = 1'b0;
    req_addr[d]   = '0;
    req_wline[d]  = '0;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    check({tag, " post resp_valid"}, LW'(resp_valid[d]), 0);
    check({tag, " post req_ready"}, LW'(req_ready[d]), 1);
    check({tag, " post mem_addr"}, LW'(mem_addr[d]), 0);
    check({tag, " post mem_wdata"}, LW'(mem_wdata[d]), 0);
    compare_strobes(tag);
  endtask

  typedef struct {
    int            d;
    bit            we;
    logic [27:0]   addr;
    logic [LW-1:0] wline;
    int            hold;
    logic [LW-1:0] exp_rline;
    bit            exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] got;
    logic          gerr;
    logic [LW-1:0] line36, line_fc, line_oob, line_b, rline;
    logic [27:0]   raddr;
    bit            seen_valid;
    int            acc, rd;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wline[d] = '0; resp_ready[d] = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = init_word(d, i);
    end
    init_bank = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    init_bank = 1'b0;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d req_ready", d), LW'(req_ready[d]), 1);
      check($sformatf("reset%0d resp_valid", d), LW'(resp_valid[d]), 0);
      check($sformatf("reset%0d mem_write_en", d), LW'(mem_write_en[d]), 0);
      check($sformatf("reset%0d mem_addr", d), LW'(mem_addr[d]), 0);
      check($sformatf("reset%0d mem_wdata", d), LW'(mem_wdata[d]), 0);
      check($sformatf("reset%0d resp_err", d), LW'(resp_err[d]), 0);
      check($sformatf("reset%0d resp_rline", d), resp_rline[d], '0);
    end

    line36   = 128'h00000044_00000033_00000022_00000011;
    line_fc  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    line_oob = 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000;
    line_b   = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
    vecs[0] = '{0, 1'b0, 28'h000, '0,       0, 128'h000000D0_000000C0_000000B0_000000A0, 1'b0};
    vecs[1] = '{0, 1'b1, 28'h006, line36,   0, line36,  1'b0};
    vecs[2] = '{0, 1'b0, 28'h004, '0,       5, line36,  1'b0};
    vecs[3] = '{0, 1'b1, 28'h0FC, line_fc,  0, line_fc, 1'b0};
    vecs[4] = '{0, 1'b0, 28'h0FE, '0,       1, line_fc, 1'b0};
`ifdef MEM_LINE_CTRL_RANGE_CHECK_EN
    vecs[5] = '{0, 1'b1, 28'h100, line_oob, 0, '0,       1'b1};
`else
    vecs[5] = '{0, 1'b1, 28'h100, line_oob, 0, line_oob, 1'b0};
`endif
    vecs[6] = '{1, 1'b0, 28'h008, '0,       0, 128'h5001000B_5001000A_50010009_50010008, 1'b0};
    vecs[7] = '{1, 1'b1, 28'h011, line_b,   0, line_b,  1'b0};
    vecs[8] = '{1, 1'b0, 28'h010, '0,       2, line_b,  1'b0};

    for (int i = 0; i < 9; i++) begin
      run_line(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wline, vecs[i].hold, 1'b0,
               $sformatf("vec%0d", i), got, gerr);
      check($sformatf("vec%0d table rline", i), got, vecs[i].exp_rline);
      check($sformatf("vec%0d table err", i), LW'(gerr), LW'(vecs[i].exp_err));
    end

    // reset in cycle T+5 of a write: only the beat-0 strobe (cycle T+3) survives
    rline = {$urandom, $urandom, $urandom, $urandom};
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 28'h40; req_wline[0] = rline;
    @(posedge clk);
    acc = cyc;
    exp_q.push_back({1'b0, 16'(acc + 3), 28'h40, rline[31:0]});
    ref_mem[0][8'h40] = rline[31:0];
    #1;
    req_valid[0] = 1'b0; req_we[0] = 1'b0; req_addr[0] = '0; req_wline[0] = '0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    check("midrst req_ready", LW'(req_ready[0]), 1);
    check("midrst resp_valid", LW'(resp_valid[0]), 0);
    check("midrst mem_addr", LW'(mem_addr[0]), 0);
    check("midrst resp_rline", resp_rline[0], '0);
    seen_valid = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (resp_valid[0] !== 1'b0) seen_valid = 1;
    end
    check("midrst no response", LW'(seen_valid), 0);
    compare_strobes("midrst");
    run_line(0, 1'b0, 28'h40, '0, 0, 1'b0, "midrst readback", got, gerr);

    // random lines against the model
    for (int i = 0; i < 24; i++) begin
      rd    = int'($urandom_range(0, 1));
      raddr = 28'($urandom_range(0, 299));
      rline = {$urandom, $urandom, $urandom, $urandom};
      run_line(rd, 1'($urandom_range(0, 1)), raddr, rline, int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), $sformatf("rand%0d", i), got, gerr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
